// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-and-add-3 binary to BCD converter.
// Takes one unsigned value per start pulse. After BIN_WIDTH shift steps it
// presents registered thousands/hundreds/tens/ones digits and a one-cycle
// done pulse. Values above MAX_VALUE saturate to 9999 and set overflow.
// Optional build macro: BCD_BLANK_LEADING_EN. When it is defined, leading
// zero digits (thousands down to tens) are replaced by 4'hF at completion,
// which the display decoder shows as blank.
//
// state | meaning
// IDLE  | waiting for start; digits hold the last result
// SHIFT | add-3 then shift once per cycle until the down-counter expires

module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 14,
  parameter int MAX_VALUE = 9999
) (
  input  logic                 clkin,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin_in,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [3:0]           ones,
  output logic [3:0]           tens,
  output logic [3:0]           hundreds,
  output logic [3:0]           thousands
);

  localparam int BCD_W  = 16;
  localparam int WORK_W = BCD_W + BIN_WIDTH;
  localparam int CNT_W  = $clog2(BIN_WIDTH + 1);
  localparam logic [BIN_WIDTH-1:0] MAX_BIN = BIN_WIDTH'(MAX_VALUE);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Working register: BCD field in the upper 16 bits, binary field below.
  logic [WORK_W-1:0] work;
  logic [WORK_W-1:0] work_adj;
  logic [WORK_W-1:0] work_shf;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;
  logic              load;
  logic              step;
  logic              finish;
  logic [BCD_W-1:0]  dig_fin;

  assign busy = (state == SHIFT);

  // State register.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control strobes; terminal count is the step that takes cnt to zero.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == CNT_W'(1)) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Add 3 to every BCD nibble that is 5 or more, then shift left by one.
  // The binary field below the BCD nibbles is never adjusted.
  always_comb begin
    work_adj = work;
    for (int i = 0; i < 4; i++) begin
      if (work_adj[BIN_WIDTH + 4*i +: 4] >= 4'd5) begin
        work_adj[BIN_WIDTH + 4*i +: 4] = work_adj[BIN_WIDTH + 4*i +: 4] + 4'd3;
      end
    end
    work_shf = {work_adj[WORK_W-2:0], 1'b0};
  end

  // Final digit formatting: saturation first, then optional leading-zero blanking.
  always_comb begin
    if (ovf) begin
      dig_fin = 16'h9999;
    end else begin
      dig_fin = work_shf[WORK_W-1 -: BCD_W];
`ifdef BCD_BLANK_LEADING_EN
      if (dig_fin[15:12] == 4'd0) begin
        dig_fin[15:12] = 4'hF;
        if (dig_fin[11:8] == 4'd0) begin
          dig_fin[11:8] = 4'hF;
          if (dig_fin[7:4] == 4'd0) begin
            dig_fin[7:4] = 4'hF;
          end
        end
      end
`endif
    end
  end

  // Working register, step down-counter and captured overflow flag.
  always_ff @(posedge clkin) begin
    if (reset) begin
      work <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else if (load) begin
      work <= {{BCD_W{1'b0}}, bin_in};
      cnt  <= CNT_W'(BIN_WIDTH);
      ovf  <= (bin_in > MAX_BIN);
    end else if (step) begin
      work <= work_shf;
      cnt  <= cnt - CNT_W'(1);
    end
  end

  // Result registers: digits and overflow only move at completion or reset.
  always_ff @(posedge clkin) begin
    if (reset) begin
      done      <= 1'b0;
      overflow  <= 1'b0;
      thousands <= 4'd0;
      hundreds  <= 4'd0;
      tens      <= 4'd0;
      ones      <= 4'd0;
    end else begin
      done <= finish;
      if (finish) begin
        overflow  <= ovf;
        thousands <= dig_fin[15:12];
        hundreds  <= dig_fin[11:8];
        tens      <= dig_fin[7:4];
        ones      <= dig_fin[3:0];
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed self-checking bench for bin_to_bcd_seq.
// Expected digit patterns are selected for the BCD_BLANK_LEADING_EN build
// when that macro is defined.

module tb_bin_to_bcd_seq;

  logic        clkin = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [3:0]  ones;
  logic [3:0]  tens;
  logic [3:0]  hundreds;
  logic [3:0]  thousands;
  logic [15:0] digs;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef BCD_BLANK_LEADING_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  bin_to_bcd_seq dut (
    .clkin     (clkin),
    .reset     (reset),
    .start     (start),
    .bin_in    (bin_in),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .ones      (ones),
    .tens      (tens),
    .hundreds  (hundreds),
    .thousands (thousands)
  );

  assign digs = {thousands, hundreds, tens, ones};

  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pick(input logic [15:0] plain, input logic [15:0] blank);
    return BLANK ? blank : plain;
  endfunction

  task automatic step_clk();
    @(posedge clkin);
    #1;
  endtask

  // Counts edges until done is seen, bounded at 40.
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      step_clk();
      cyc++;
    end while (!done && cyc < 40);
  endtask

  task automatic run_conv(input string tag, input logic [13:0] val,
                          input logic [15:0] exp_d, input logic exp_ovf);
    int cyc;
    start  = 1'b1;
    bin_in = val;
    step_clk();
    start  = 1'b0;
    chk({tag, "_busy_on"}, busy, 1);
    wait_done(cyc);
    chk({tag, "_latency"}, cyc, 14);
    chk({tag, "_digits"}, digs, exp_d);
    chk({tag, "_ovf"}, overflow, exp_ovf);
    chk({tag, "_busy_off"}, busy, 0);
    step_clk();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_digits_hold"}, digs, exp_d);
  endtask

  initial begin
    int cyc;
    int busy_cnt;
    int done_cnt;
    int done_at;

    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (2) step_clk();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_digits", digs, 16'h0000);
    reset = 1'b0;
    step_clk();

    run_conv("zero", 14'd0, pick(16'h0000, 16'hFFF0), 1'b0);
    run_conv("v1234", 14'd1234, 16'h1234, 1'b0);
    run_conv("v9999", 14'd9999, 16'h9999, 1'b0);
    run_conv("v10000", 14'd10000, 16'h9999, 1'b1);
    run_conv("v16383", 14'd16383, 16'h9999, 1'b1);
    run_conv("v42", 14'd42, pick(16'h0042, 16'hFF42), 1'b0);

    // Second start during conversion must be ignored.
    start  = 1'b1;
    bin_in = 14'd1234;
    step_clk();
    start    = 1'b0;
    busy_cnt = busy ? 1 : 0;
    done_cnt = 0;
    done_at  = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 5) begin
        start  = 1'b1;
        bin_in = 14'd5678;
      end
      step_clk();
      if (c == 5) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = c;
      end
    end
    chk("ign_busy_cycles", busy_cnt, 14);
    chk("ign_done_count", done_cnt, 1);
    chk("ign_done_at", done_at, 14);
    chk("ign_digits", digs, 16'h1234);

    // Start held high: back-to-back conversions every 15 cycles.
    bin_in = 14'd7;
    start  = 1'b1;
    step_clk();
    wait_done(cyc);
    chk("b2b_lat0", cyc, 14);
    chk("b2b_dig0", digs, pick(16'h0007, 16'hFFF7));
    bin_in = 14'd80;
    wait_done(cyc);
    chk("b2b_lat1", cyc, 15);
    chk("b2b_dig1", digs, pick(16'h0080, 16'hFF80));
    bin_in = 14'd905;
    wait_done(cyc);
    start = 1'b0;
    chk("b2b_lat2", cyc, 15);
    chk("b2b_dig2", digs, pick(16'h0905, 16'hF905));
    step_clk();
    chk("b2b_idle", busy, 0);

    // Reset in the middle of a conversion.
    start  = 1'b1;
    bin_in = 14'd4321;
    step_clk();
    start = 1'b0;
    repeat (5) step_clk();
    chk("abort_busy_before", busy, 1);
    reset = 1'b1;
    step_clk();
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_digits", digs, 16'h0000);
    chk("abort_ovf", overflow, 0);
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      step_clk();
      if (done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    run_conv("v4321", 14'd4321, 16'h4321, 1'b0);

    // Reset and start together: reset wins.
    reset  = 1'b1;
    start  = 1'b1;
    bin_in = 14'd100;
    step_clk();
    reset = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", busy, 0);
    step_clk();
    chk("rst_start_busy2", busy, 0);
    chk("rst_start_digits", digs, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
